sap2_core: RTL and testbench
============================

Name: sap2_core

Overview:
- Parametrised successor to the SAP-1 computer: accumulator CPU with width-generic datapath, internal RAM, front-panel programming, carry/zero flags and conditional jumps.
- Variable-length instruction cycle (2 or 3 states) replaces the fixed 6-T ring.
- Instantiated by top.v for board use and by tb.v for simulation.

Parameters:
- DATA_W, 8: datapath and memory word width; must be >= ADDR_W+4.
- ADDR_W, 4: address width; RAM depth is 2**ADDR_W words.

Ports:
- sysclk  in  1  system clock; all state changes on its rising edge.
- fp_clear_n  in  1  asynchronous active-low reset.
- clken  in  1  step enable; registers update only on edges where clken=1.
- fp_prog  in  1  program mode; CPU frozen while 1.
- fp_write  in  1  panel write strobe; honoured only while fp_prog=1 and clken=1.
- fp_adr  in  ADDR_W  panel address.
- fp_data  in  DATA_W  panel write data.
- fp_rdata  out  DATA_W  combinational mem[fp_adr], for panel readback.
- o_out  out  DATA_W  output register.
- o_valid  out  1  one-clken-step pulse when OUT executes.
- pc_out  out  ADDR_W  program counter.
- state_out  out  2  FSM state code (FETCH=0, EXEC=1, ALU=2, HALT=3).
- flag_c, flag_z  out  1 each  carry and zero flags.
- halt  out  1  high in HALT state.

Behaviour:
- Instruction word: opcode = word[DATA_W-1:DATA_W-4]; operand = word[ADDR_W-1:0]; other bits ignored.
- RAM: asynchronous read, synchronous write (clken-qualified). Not reset; contents survive fp_clear_n.
- Reset (async, fp_clear_n=0): PC, IR, A, B, O = 0; flags = 0; o_valid = 0; state = FETCH; halt = 0.
- No register update occurs when clken=0; o_valid holds its value.
- fp_prog=1: FSM and all CPU registers hold. Panel write mem[fp_adr] <= fp_data when fp_write. On fp_prog deassert, execution resumes from the held state.
- FETCH: IR <= mem[PC]; PC <= PC+1 mod 2**ADDR_W (wraps to 0); next state EXEC.
- EXEC, by opcode:
  - 0 LDA: A <= mem[op]; go to FETCH.
  - 1 ADD / 2 SUB: B <= mem[op]; go to ALU.
  - 3 STA: mem[op] <= A; go to FETCH.
  - 4 LDI: A <= zero-extended op; go to FETCH.
  - 5 JMP: PC <= op; go to FETCH.
  - 6 JC: PC <= op if flag_c; go to FETCH.
  - 7 JZ: PC <= op if flag_z; go to FETCH.
  - E OUT: O <= A; o_valid <= 1 for this step only; go to FETCH.
  - F HLT: go to HALT.
  - All other opcodes: NOP; go to FETCH.
- ALU state:
  - ADD: A <= (A+B) mod 2**DATA_W; flag_c = carry out.
  - SUB: A <= A + ~B + 1; flag_c = 1 iff A >= B (no borrow).
  - Both: flag_z = (result == 0); go to FETCH.
- Flags change only in the ALU state; LDA and LDI do not affect flags.
- HALT: absorbing state; only reset leaves it. fp_prog writes still work in HALT.
- Cycle counts in clken steps: LDA/STA/LDI/JMP/Jcc/OUT/NOP = 2; ADD/SUB = 3.
- Reset mid-instruction: immediate abort; partial results discarded except a RAM write already committed.
- STA and panel writes cannot collide, since the CPU is frozen while fp_prog=1.

Test Plan:
- Reset/prog: assert fp_clear_n=0 mid-ADD, then release -> PC=0, A=0, state_out=0, flags 0. Program mem[0]=0x0F via panel -> fp_rdata=0x0F.
- Add chain: mem = {LDA 9, ADD A, OUT, HLT}, mem[9]=0x05, mem[A]=0x03 -> o_out=0x08, one o_valid pulse, halt=1 after 9 clken steps.
- Carry/zero: A=0xFF plus B=0x01 -> A=0x00, flag_c=1, flag_z=1. Then SUB 0x01 from 0x00 -> A=0xFF, flag_c=0, flag_z=0.
- Conditional jumps: JC 5 with flag_c=0 -> PC=next sequential. JZ 5 with flag_z=1 -> PC=5. JMP from addr 15 -> target honoured; plain fetch at 15 -> PC wraps to 0.
- Countdown loop using STA/LDA/SUB/JZ from 3 -> o_out sequence 3,2,1, then halt. Check clken=0 gaps freeze all state, and fp_prog=1 mid-run freezes PC and resumes it unchanged.
- Parameter sweep: DATA_W=12, ADDR_W=6 -> LDI 0x3F gives A=0x03F; PC wraps at 63; carry taken from bit 12.

Source files
------------

// File: rtl/sap2_core.sv
// SAP-2 accumulator CPU: width-generic datapath, internal RAM with front-panel
// programming, carry/zero flags, conditional jumps and a 2/3-state instruction cycle.
module sap2_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              sysclk,
   input  logic              fp_clear_n,
   input  logic              clken,
   input  logic              fp_prog,
   input  logic              fp_write,
   input  logic [ADDR_W-1:0] fp_adr,
   input  logic [DATA_W-1:0] fp_data,
   output logic [DATA_W-1:0] fp_rdata,
   output logic [DATA_W-1:0] o_out,
   output logic              o_valid,
   output logic [ADDR_W-1:0] pc_out,
   output logic [1:0]        state_out,
   output logic              flag_c,
   output logic              flag_z,
   output logic              halt
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      ALU   = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_LDI = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JC  = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state, next_state;
   logic [ADDR_W-1:0] pc;
   logic [3:0]        ir_op;
   logic [ADDR_W-1:0] ir_arg;
   logic [DATA_W-1:0] a_reg, b_reg;

   logic ld_ir, inc_pc, ld_pc, ld_a_mem, ld_a_imm, ld_b, st_mem, ld_o, alu_go;
   logic step;
   logic is_sub;
   logic [DATA_W:0] alu_sum;

   // The CPU advances only on enabled steps while the panel is not in program mode.
   assign step = clken & ~fp_prog;

   always_ff @(posedge sysclk or negedge fp_clear_n) begin
      if (!fp_clear_n)
         state <= FETCH;
      else if (step)
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         FETCH: next_state = EXEC;
         EXEC: begin
            if (ir_op == OP_ADD || ir_op == OP_SUB)
               next_state = ALU;
            else if (ir_op == OP_HLT)
               next_state = HALT;
            else
               next_state = FETCH;
         end
         ALU:     next_state = FETCH;
         HALT:    next_state = HALT;
         default: next_state = FETCH;
      endcase
   end

   always_comb begin
      ld_ir    = 1'b0;
      inc_pc   = 1'b0;
      ld_pc    = 1'b0;
      ld_a_mem = 1'b0;
      ld_a_imm = 1'b0;
      ld_b     = 1'b0;
      st_mem   = 1'b0;
      ld_o     = 1'b0;
      alu_go   = 1'b0;
      case (state)
         FETCH: begin
            ld_ir  = 1'b1;
            inc_pc = 1'b1;
         end
         EXEC: begin
            case (ir_op)
               OP_LDA:          ld_a_mem = 1'b1;
               OP_ADD, OP_SUB:  ld_b     = 1'b1;
               OP_STA:          st_mem   = 1'b1;
               OP_LDI:          ld_a_imm = 1'b1;
               OP_JMP:          ld_pc    = 1'b1;
               OP_JC:           ld_pc    = flag_c;
               OP_JZ:           ld_pc    = flag_z;
               OP_OUT:          ld_o     = 1'b1;
               default:         ;
            endcase
         end
         ALU:     alu_go = 1'b1;
         default: ;
      endcase
   end

   // SUB is A + ~B + 1, so the carry out doubles as the no-borrow flag.
   assign is_sub  = (ir_op == OP_SUB);
   assign alu_sum = {1'b0, a_reg} + {1'b0, (is_sub ? ~b_reg : b_reg)} + (DATA_W+1)'(is_sub);

   always_ff @(posedge sysclk or negedge fp_clear_n) begin
      if (!fp_clear_n) begin
         pc      <= '0;
         ir_op   <= '0;
         ir_arg  <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         o_out   <= '0;
         flag_c  <= 1'b0;
         flag_z  <= 1'b0;
         o_valid <= 1'b0;
      end else if (clken) begin
         o_valid <= step & ld_o;
         if (step) begin
            if (ld_ir) begin
               ir_op  <= mem[pc][DATA_W-1 -: 4];
               ir_arg <= mem[pc][ADDR_W-1:0];
            end
            if (inc_pc)
               pc <= pc + ADDR_W'(1);
            else if (ld_pc)
               pc <= ir_arg;
            if (ld_a_mem)
               a_reg <= mem[ir_arg];
            else if (ld_a_imm)
               a_reg <= DATA_W'(ir_arg);
            else if (alu_go)
               a_reg <= alu_sum[DATA_W-1:0];
            if (ld_b)
               b_reg <= mem[ir_arg];
            if (ld_o)
               o_out <= a_reg;
            if (alu_go) begin
               flag_c <= alu_sum[DATA_W];
               flag_z <= (alu_sum[DATA_W-1:0] == '0);
            end
         end
      end
   end

   // RAM has no reset so panel-loaded programs survive a clear.
   always_ff @(posedge sysclk) begin
      if (clken) begin
         if (fp_prog && fp_write)
            mem[fp_adr] <= fp_data;
         else if (step && st_mem)
            mem[ir_arg] <= a_reg;
      end
   end

   assign fp_rdata  = mem[fp_adr];
   assign pc_out    = pc;
   assign state_out = state;
   assign halt      = (state == HALT);

endmodule

// File: tb/tb_sap2_core.sv
// Directed self-checking bench for sap2_core: an 8/4 instance for the main
// instruction tests and a 12/6 instance for the wide-parameter checks.
module tb_sap2_core;

   logic sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   logic       clear_n, clken, prog, write;
   logic [3:0] adr;
   logic [7:0] data;
   logic [7:0] rdata, out_val;
   logic       out_valid, flag_c, flag_z, halt;
   logic [3:0] pc;
   logic [1:0] state;

   logic        w_clear_n, w_prog, w_write;
   logic [5:0]  w_adr;
   logic [11:0] w_data, w_rdata, w_out_val;
   logic        w_out_valid, w_flag_c, w_flag_z, w_halt;
   logic [5:0]  w_pc;
   logic [1:0]  w_state;

   int total = 0;
   int bad   = 0;

   sap2_core #(.DATA_W(8), .ADDR_W(4)) u_dut (
      .sysclk(sysclk), .fp_clear_n(clear_n), .clken(clken), .fp_prog(prog),
      .fp_write(write), .fp_adr(adr), .fp_data(data), .fp_rdata(rdata),
      .o_out(out_val), .o_valid(out_valid), .pc_out(pc), .state_out(state),
      .flag_c(flag_c), .flag_z(flag_z), .halt(halt)
   );

   sap2_core #(.DATA_W(12), .ADDR_W(6)) u_wide (
      .sysclk(sysclk), .fp_clear_n(w_clear_n), .clken(clken), .fp_prog(w_prog),
      .fp_write(w_write), .fp_adr(w_adr), .fp_data(w_data), .fp_rdata(w_rdata),
      .o_out(w_out_val), .o_valid(w_out_valid), .pc_out(w_pc), .state_out(w_state),
      .flag_c(w_flag_c), .flag_z(w_flag_z), .halt(w_halt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Advance n clock edges, leaving the bench 1ns after the last rising edge.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   task automatic writeWord(input logic [3:0] a, input logic [7:0] d);
      prog  = 1'b1;
      write = 1'b1;
      adr   = a;
      data  = d;
      applyStimulus(1);
      write = 1'b0;
   endtask

   task automatic writeWide(input logic [5:0] a, input logic [11:0] d);
      w_prog  = 1'b1;
      w_write = 1'b1;
      w_adr   = a;
      w_data  = d;
      applyStimulus(1);
      w_write = 1'b0;
   endtask

   task automatic startRun();
      clear_n = 1'b0;
      #2;
      clear_n = 1'b1;
      prog    = 1'b0;
   endtask

   initial begin
      logic [7:0] outs [8];
      int nouts;
      int pulses;

      clear_n = 1'b0; clken = 1'b1; prog = 1'b1; write = 1'b0; adr = '0; data = '0;
      w_clear_n = 1'b0; w_prog = 1'b1; w_write = 1'b0; w_adr = '0; w_data = '0;
      #1;
      checkOutput("rst_pc", 32'(pc), 0);
      checkOutput("rst_state", 32'(state), 0);
      checkOutput("rst_halt", 32'(halt), 0);
      checkOutput("rst_ovalid", 32'(out_valid), 0);
      checkOutput("rst_flags", {30'd0, flag_c, flag_z}, 0);
      #2;
      clear_n = 1'b1;

      // Panel write/readback, then the add chain aborted mid-ADD by a clear.
      writeWord(4'h0, 8'h0F);
      adr = 4'h0;
      #1;
      checkOutput("panel_rdata", 32'(rdata), 32'h0F);
      writeWord(4'h0, 8'h09);
      writeWord(4'h1, 8'h1A);
      writeWord(4'h2, 8'hE0);
      writeWord(4'h3, 8'hF0);
      writeWord(4'h9, 8'h05);
      writeWord(4'hA, 8'h03);
      startRun();
      applyStimulus(4);
      checkOutput("midadd_state", 32'(state), 2);
      clear_n = 1'b0;
      #1;
      checkOutput("midadd_rst_pc", 32'(pc), 0);
      checkOutput("midadd_rst_state", 32'(state), 0);
      checkOutput("midadd_rst_flags", {30'd0, flag_c, flag_z}, 0);
      checkOutput("midadd_rst_out", 32'(out_val), 0);
      clear_n = 1'b1;

      pulses = 0;
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(1);
         if (out_valid) pulses++;
         if (i == 7) begin
            clken = 1'b0;
            applyStimulus(2);
            checkOutput("ovalid_hold", 32'(out_valid), 1);
            clken = 1'b1;
         end
         if (i == 8) checkOutput("add_not_halted", 32'(halt), 0);
      end
      checkOutput("add_out", 32'(out_val), 32'h08);
      checkOutput("add_pulses", 32'(pulses), 1);
      checkOutput("add_halt", 32'(halt), 1);
      checkOutput("add_pc", 32'(pc), 4);
      applyStimulus(3);
      checkOutput("halt_absorb", 32'(state), 3);
      writeWord(4'hC, 8'h5A);
      adr = 4'hC;
      #1;
      checkOutput("halt_panel_write", 32'(rdata), 32'h5A);

      // Carry and zero flags: 0xFF + 1, then 0x00 - 1.
      writeWord(4'h0, 8'h08);
      writeWord(4'h1, 8'h19);
      writeWord(4'h2, 8'hE0);
      writeWord(4'h3, 8'h29);
      writeWord(4'h4, 8'hE0);
      writeWord(4'h5, 8'hF0);
      writeWord(4'h8, 8'hFF);
      writeWord(4'h9, 8'h01);
      startRun();
      applyStimulus(5);
      checkOutput("add_carry", 32'(flag_c), 1);
      checkOutput("add_zero", 32'(flag_z), 1);
      applyStimulus(2);
      checkOutput("add_wrap_out", 32'(out_val), 32'h00);
      applyStimulus(3);
      checkOutput("sub_borrow_c", 32'(flag_c), 0);
      checkOutput("sub_borrow_z", 32'(flag_z), 0);
      applyStimulus(2);
      checkOutput("sub_out", 32'(out_val), 32'hFF);

      // Conditional and unconditional jumps, including a fetch at the top address.
      writeWord(4'h0, 8'h65);
      writeWord(4'h1, 8'h40);
      writeWord(4'h2, 8'h18);
      writeWord(4'h3, 8'h75);
      writeWord(4'h5, 8'h5F);
      writeWord(4'h7, 8'h80);
      writeWord(4'h8, 8'h00);
      writeWord(4'hF, 8'h57);
      startRun();
      applyStimulus(2);
      checkOutput("jc_not_taken", 32'(pc), 1);
      applyStimulus(5);
      checkOutput("zero_set", 32'(flag_z), 1);
      applyStimulus(2);
      checkOutput("jz_taken", 32'(pc), 5);
      applyStimulus(2);
      checkOutput("jmp_to_15", 32'(pc), 15);
      applyStimulus(1);
      checkOutput("pc_wrap", 32'(pc), 0);
      applyStimulus(1);
      checkOutput("jmp_from_15", 32'(pc), 7);
      applyStimulus(2);
      checkOutput("nop_pc", 32'(pc), 8);
      checkOutput("nop_state", 32'(state), 0);

      // Countdown loop with clken gaps and a program-mode pause mid-run.
      writeWord(4'h0, 8'h43);
      writeWord(4'h1, 8'h3E);
      writeWord(4'h2, 8'h0E);
      writeWord(4'h3, 8'hE0);
      writeWord(4'h4, 8'h2D);
      writeWord(4'h5, 8'h78);
      writeWord(4'h6, 8'h3E);
      writeWord(4'h7, 8'h52);
      writeWord(4'h8, 8'hF0);
      writeWord(4'hD, 8'h01);
      startRun();
      applyStimulus(5);
      checkOutput("loop_pc5", 32'(pc), 3);
      clken = 1'b0;
      applyStimulus(3);
      checkOutput("gap_pc", 32'(pc), 3);
      checkOutput("gap_state", 32'(state), 1);
      clken = 1'b1;
      prog  = 1'b1;
      applyStimulus(3);
      checkOutput("prog_pc", 32'(pc), 3);
      checkOutput("prog_state", 32'(state), 1);
      prog  = 1'b0;
      nouts = 0;
      for (int i = 0; i < 400 && !halt; i++) begin
         applyStimulus(1);
         if (out_valid && nouts < 8) begin
            outs[nouts] = out_val;
            nouts++;
         end
      end
      checkOutput("loop_halt", 32'(halt), 1);
      checkOutput("loop_count", 32'(nouts), 3);
      checkOutput("loop_out0", 32'(outs[0]), 3);
      checkOutput("loop_out1", 32'(outs[1]), 2);
      checkOutput("loop_out2", 32'(outs[2]), 1);

      // Wide instance: immediate zero-extension, carry from bit 12, PC wrap at 63.
      writeWide(6'd0,  12'h43F);
      writeWide(6'd1,  12'hE00);
      writeWide(6'd2,  12'h03C);
      writeWide(6'd3,  12'h13D);
      writeWide(6'd4,  12'h53E);
      writeWide(6'd62, 12'h800);
      writeWide(6'd63, 12'h800);
      writeWide(6'd60, 12'hFFF);
      writeWide(6'd61, 12'h001);
      w_clear_n = 1'b0;
      #2;
      w_clear_n = 1'b1;
      w_prog    = 1'b0;
      applyStimulus(4);
      checkOutput("wide_ldi", 32'(w_out_val), 32'h03F);
      applyStimulus(5);
      checkOutput("wide_carry", 32'(w_flag_c), 1);
      checkOutput("wide_zero", 32'(w_flag_z), 1);
      applyStimulus(2);
      checkOutput("wide_jmp", 32'(w_pc), 62);
      applyStimulus(2);
      checkOutput("wide_pc63", 32'(w_pc), 63);
      applyStimulus(1);
      checkOutput("wide_wrap", 32'(w_pc), 0);
      w_prog = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
